servo_ramp_ctrl: RTL and testbench



---
 rtl/servo_ramp_ctrl.sv | 164 ++++++++++++++++
 tb/tb_servo_ramp_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: Avalon-MM servo pulse sequencer.
// One pulse is generated per fixed-length frame. Its width slews toward a
// software target by STEP microseconds, and changes only at frame boundaries.
// Optional feature macro: SERVO_WATCHDOG_EN. When it is defined, a missing
// kick for WDOG_FRAMES frames forces the target back to PW_NEUTRAL.
// Bus handshake: a write is accepted on any cycle with avs_write high. A read
// with avs_read high returns data on avs_readdata one cycle later. There is no
// waitrequest, and a same-cycle read returns the value from before the write.
module servo_ramp_ctrl #(
  parameter int TICK_DIV    = 50,
  parameter int FRAME_US    = 20000,
  parameter int PW_MIN      = 1000,
  parameter int PW_MAX      = 2000,
  parameter int PW_NEUTRAL  = 1500,
  parameter int WDOG_FRAMES = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        pwm_out
);

  localparam int          PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] PW_MIN_W  = 16'(PW_MIN);
  localparam logic [15:0] PW_MAX_W  = 16'(PW_MAX);
  localparam logic [15:0] PW_NEU_W  = 16'(PW_NEUTRAL);
  localparam logic [15:0] FRAME_END = 16'(FRAME_US - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [15:0]        frame_cnt_q;
  logic [15:0]        target_q;
  logic [15:0]        step_q;
  logic               enable_q;
  logic               en_l_q;
  logic [15:0]        cur_width_q, cur_width_d;
  logic               pwm_q;
  logic [31:0]        rdata_q, rdata_d;

  logic        tick, boundary, at_target;
  logic        wr_target, wr_step, wr_ctrl;
  logic [15:0] wdata16, target_clamped;
  logic [15:0] diff, delta;
  logic        trip, wdog_tripped;
  logic        unused_wdata;

  assign unused_wdata = ^{avs_writedata[31:16], avs_writedata[1]};

  assign tick     = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign boundary = tick && (frame_cnt_q == FRAME_END);
  assign at_target = (cur_width_q == target_q);

  assign wr_target = avs_write && (avs_address == 2'd0);
  assign wr_step   = avs_write && (avs_address == 2'd1);
  assign wr_ctrl   = avs_write && (avs_address == 2'd3);

  assign wdata16 = avs_writedata[15:0];
  assign target_clamped = (wdata16 < PW_MIN_W) ? PW_MIN_W :
                          (wdata16 > PW_MAX_W) ? PW_MAX_W : wdata16;

  // Microsecond prescaler and frame counter; a frame boundary is the wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      frame_cnt_q <= '0;
    end else if (tick) begin
      presc_q     <= '0;
      frame_cnt_q <= boundary ? 16'd0 : frame_cnt_q + 16'd1;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // Ramp step: move by min(STEP, distance); the distance is formed first so nothing wraps.
  always_comb begin
    if (target_q >= cur_width_q) diff = target_q - cur_width_q;
    else                         diff = cur_width_q - target_q;
    if ((step_q == 16'd0) || (step_q > diff)) delta = diff;
    else                                      delta = step_q;
    cur_width_d = cur_width_q;
    if (boundary) begin
      if (target_q >= cur_width_q) cur_width_d = cur_width_q + delta;
      else                         cur_width_d = cur_width_q - delta;
    end
  end

`ifdef SERVO_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_FRAMES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_tripped_q;
  logic              kick;

  assign kick = wr_target || (wr_ctrl && avs_writedata[1]);
  // A kick on the trip boundary wins, so the trip is suppressed.
  assign trip = boundary && !kick && !wdog_tripped_q &&
                (wdog_cnt_q == WDOG_W'(WDOG_FRAMES - 1));
  assign wdog_tripped = wdog_tripped_q;

  // Watchdog: count boundaries since the last kick, and latch the trip.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q     <= '0;
      wdog_tripped_q <= 1'b0;
    end else if (kick) begin
      wdog_cnt_q     <= '0;
      wdog_tripped_q <= 1'b0;
    end else if (boundary && !wdog_tripped_q) begin
      wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
      if (trip) wdog_tripped_q <= 1'b1;
    end
  end
`else
  assign trip         = 1'b0;
  assign wdog_tripped = 1'b0;
`endif

  // Register file, ramp state, and enable latched per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q    <= PW_NEU_W;
      step_q      <= '0;
      enable_q    <= 1'b0;
      en_l_q      <= 1'b0;
      cur_width_q <= PW_NEU_W;
    end else begin
      if (wr_target)  target_q <= target_clamped;
      else if (trip)  target_q <= PW_NEU_W;
      if (wr_step)    step_q   <= wdata16;
      if (wr_ctrl)    enable_q <= avs_writedata[0];
      if (boundary)   en_l_q   <= enable_q;
      cur_width_q <= cur_width_d;
    end
  end

  // Read mux; unused bits and the kick bit read as zero.
  always_comb begin
    rdata_d = '0;
    case (avs_address)
      2'd0: rdata_d = {16'd0, target_q};
      2'd1: rdata_d = {16'd0, step_q};
      2'd2: rdata_d = {cur_width_q, 14'd0, wdog_tripped, at_target};
      default: rdata_d = {31'd0, enable_q};
    endcase
  end

  // Registered read data and glitch-free registered pulse output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      if (avs_read) rdata_q <= rdata_d;
      pwm_q <= en_l_q && (frame_cnt_q < cur_width_q);
    end
  end

  assign avs_readdata = rdata_q;
  assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed testbench for servo_ramp_ctrl with small timing parameters.
// Each microsecond is 2 clk long, and each frame is 100 us, which is 200 clk.
module tb_servo_ramp_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        pwm_out;

  int total  = 0;
  int passed = 0;

  servo_ramp_ctrl #(
    .TICK_DIV(2), .FRAME_US(100), .PW_MIN(10), .PW_MAX(20),
    .PW_NEUTRAL(15), .WDOG_FRAMES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .pwm_out(pwm_out)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic kick();
    bus_write(2'd3, 32'h3);
  endtask

  // Wait for the next low-to-high transition of pwm_out, sampled on negedges.
  task automatic wait_rise(output bit ok);
    int n = 0;
    while (pwm_out !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    while (pwm_out !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    ok = (pwm_out === 1'b1);
  endtask

  // Measure the width in clk of the next full pulse.
  task automatic measure_pulse(input string tag, output int w);
    bit ok;
    int n = 0;
    wait_rise(ok);
    check({tag, "_rise"}, 32'(ok), 32'd1);
    w = ok ? 1 : 0;
    while (ok && n < 1000) begin
      @(negedge clk); n++;
      if (pwm_out === 1'b1) w++;
      else break;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int w, lo, hi;
    bit ok;

    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_rdata", avs_readdata, 32'd0);
    reset_n = 1'b1;

    bus_read(2'd0, rd); check("reset_target", rd, 32'd15);
    bus_read(2'd1, rd); check("reset_step", rd, 32'd0);
    bus_read(2'd2, rd); check("reset_status", rd, 32'h000F0001);
    bus_read(2'd3, rd); check("reset_ctrl", rd, 32'd0);

    // Enable: 15 us pulse in a 200-clk frame.
    bus_write(2'd3, 32'h1);
    measure_pulse("en_p1", w); check("en_p1_width", 32'(w), 32'd30);
    lo = 1;
    while (lo < 1000) begin
      @(negedge clk);
      if (pwm_out === 1'b1) break;
      lo++;
    end
    check("en_low_time", 32'(lo), 32'd170);
    kick();
    measure_pulse("en_p2", w); check("en_p2_width", 32'(w), 32'd30);
    kick();
    bus_read(2'd2, rd); check("en_status", rd, 32'h000F0001);

    // Ramp: STEP=2 toward 20 gives 17, 19, 20, 20.
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'd20);
    measure_pulse("ramp1", w); check("ramp1_width", 32'(w), 32'd34);
    kick();
    bus_read(2'd2, rd); check("ramp1_status", rd, 32'h00110000);
    measure_pulse("ramp2", w); check("ramp2_width", 32'(w), 32'd38);
    kick();
    measure_pulse("ramp3", w); check("ramp3_width", 32'(w), 32'd40);
    kick();
    bus_read(2'd2, rd); check("ramp3_status", rd, 32'h00140001);
    measure_pulse("ramp4", w); check("ramp4_width", 32'(w), 32'd40);
    kick();

    // Clamping of the target on write.
    bus_write(2'd0, 32'd5);
    bus_read(2'd0, rd); check("clamp_low", rd, 32'd10);
    bus_write(2'd0, 32'h0000FFFF);
    bus_read(2'd0, rd); check("clamp_high", rd, 32'd20);
    bus_read(2'd3, rd); check("ctrl_kick_reads0", rd, 32'd1);

    // STEP=0 jumps straight to the target.
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'd15);
    measure_pulse("jump", w); check("jump_width", 32'(w), 32'd30);
    kick();

    // Clear enable 3 us into a pulse: that pulse completes, and the next frame is empty.
    wait_rise(ok);
    check("dis_rise", 32'(ok), 32'd1);
    hi = ok ? 1 : 0;
    for (int k = 1; ok && k < 1000; k++) begin
      @(negedge clk);
      if (k == 6) begin avs_address = 2'd3; avs_writedata = 32'h0; avs_write = 1'b1; end
      if (k == 7) avs_write = 1'b0;
      if (pwm_out === 1'b1) hi++;
      else break;
    end
    avs_write = 1'b0;
    check("dis_width", 32'(hi), 32'd30);
    bus_read(2'd3, rd); check("dis_ctrl", rd, 32'd0);
    hi = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
    check("dis_no_pulse", 32'(hi), 32'd0);

`ifdef SERVO_WATCHDOG_EN
    // Watchdog: target 20, STEP 0, no kicks for three frames.
    bus_write(2'd3, 32'h1);
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'd20);
    measure_pulse("wd1", w); check("wd1_width", 32'(w), 32'd40);
    measure_pulse("wd2", w); check("wd2_width", 32'(w), 32'd40);
    measure_pulse("wd3", w); check("wd3_width", 32'(w), 32'd40);
    bus_read(2'd2, rd); check("wd_tripped_status", rd, 32'h00140002);
    measure_pulse("wd4", w); check("wd4_width", 32'(w), 32'd30);
    bus_write(2'd0, 32'd12);
    bus_read(2'd2, rd); check("wd_cleared_status", rd, 32'h000F0000);
    measure_pulse("wd5", w); check("wd5_width", 32'(w), 32'd24);
`else
    // Without the watchdog, long idle never sets STATUS bit1.
    bus_read(2'd2, rd); check("nowd_status", rd, 32'h000F0001);
`endif

    // Asynchronous reset during a pulse.
    bus_write(2'd3, 32'h1);
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'd20);
    wait_rise(ok);
    check("rst_rise", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    bus_read(2'd0, rd); check("rst_pre_target", rd, 32'd20);
    #2 reset_n = 1'b0;
    #1;
    check("rst_pwm_now", 32'(pwm_out), 32'd0);
    check("rst_rdata_now", avs_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd0, rd); check("rst_target", rd, 32'd15);
    bus_read(2'd1, rd); check("rst_step", rd, 32'd0);
    bus_read(2'd2, rd); check("rst_status", rd, 32'h000F0001);
    bus_read(2'd3, rd); check("rst_ctrl", rd, 32'd0);
    hi = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
    end
    check("rst_no_pulse", 32'(hi), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
